fifo_ctrl: RTL
==============

Name: fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the block RAM (the `ram` module) and drives its write port and read address.
- The RAM registers the read address and reads combinationally, so `ram_dout` is valid one cycle after `ram_raddr` is presented.
- Turns that RAM into a first-word-fall-through FIFO with push/pop handshakes, occupancy count, threshold flag and sticky error flags.
- All storage lives in the RAM; this block holds only pointers, count and flags.

Parameters:
- ADDR_WIDTH, 6, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 4, data word width.
- AF_THRESH, 48, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push request.
- wr_data  in  DATA_WIDTH  push data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- rd_en  in  1  pop request.
- rd_data  out  DATA_WIDTH  head-of-FIFO data; meaningful only while rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.
- ram_we  out  1  to RAM we.
- ram_waddr  out  ADDR_WIDTH  to RAM waddr.
- ram_wdata  out  DATA_WIDTH  to RAM din.
- ram_raddr  out  ADDR_WIDTH  to RAM raddr.
- ram_dout  in  DATA_WIDTH  from RAM dout.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Internal state: wr_ptr and rd_ptr (ADDR_WIDTH bits each, natural modulo-DEPTH wrap), cnt (ADDR_WIDTH+1 bits), overflow and underflow registers.
- Accept terms, combinational:
  - push = wr_en & ~full & ~rst.
  - pop = rd_en & rd_valid & ~rst.
- Push and pop are independent:
  - Push while full is rejected, even if a pop occurs in the same cycle.
  - Pop while empty is rejected, even if a push occurs in the same cycle.
- RAM drive, combinational:
  - ram_we = push; ram_waddr = wr_ptr; ram_wdata = wr_data.
  - ram_raddr = pop ? rd_ptr+1 : rd_ptr, wrapping to 0 after DEPTH-1. During rst, ram_raddr = 0.
- Read path:
  - rd_data = ram_dout, combinational pass-through.
  - Because ram_raddr always presents the post-edge head pointer, ram_dout after each edge equals mem[rd_ptr]. No output register and no bubble.
- Write to empty FIFO: the write and the read-address register update on the same edge, and the RAM returns the newly written word. rd_valid and the correct rd_data therefore appear together one cycle after the push cycle (latency 1).
- Posedge update:
  - wr_ptr += push; rd_ptr += pop.
  - cnt: +1 on push only, -1 on pop only, unchanged on both or neither.
  - overflow |= wr_en & full; underflow |= rd_en & ~rd_valid.
- Outputs are decoded from registered state only: count = cnt; full = (cnt == DEPTH); rd_valid = (cnt != 0); almost_full = (cnt >= AF_THRESH).
- Reset values: wr_ptr = rd_ptr = cnt = 0; full = 0; almost_full = 0; rd_valid = 0; overflow = underflow = 0; ram_we = 0.
- Reset mid-operation: all contents are logically discarded. The first push after rst deasserts writes address 0. RAM contents are not cleared.
- Both flags clear only on rst.
- Invariant: cnt == (wr_ptr - rd_ptr) mod DEPTH, except that cnt == DEPTH when the pointers are equal and full.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release → count=0, rd_valid=0, full=0, almost_full=0, overflow=0, underflow=0, ram_we=0.
- Single push: push 4'hA at cycle 0 → cycle 1: rd_valid=1, rd_data=4'hA, count=1. Pop at cycle 1 → cycle 2: rd_valid=0, count=0.
- Fill and ordering: push 0..63 (data = index mod 16) with no pops → count=64, full=1. almost_full first rises the cycle after the 48th push. Drain 64 pops with rd_en held high → data returned in order, one word per cycle, no bubbles; rd_valid drops after the last pop.
- Errors:
  - wr_en=1 while full → write suppressed (ram_we=0), count stays 64, overflow=1 and remains 1.
  - rd_en=1 while empty → underflow=1.
- Simultaneous and wrap: hold count=10, then assert wr_en and rd_en for 200 cycles → count stays 10, pointers wrap past 63, output sequence equals input sequence delayed by 10 entries.
- Reset mid-operation: count=20, overflow=1, assert rst for one cycle → count=0, rd_valid=0, flags 0. The next push writes ram_waddr=0, and its data appears on rd_data one cycle later.

Source files
------------

// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
//
// Purpose:
//   Synchronous first-word-fall-through FIFO controller for an external
//   block RAM. The RAM has a registered read address and a combinational
//   read, so its dout is valid one cycle after raddr is presented.
//   All data lives in the RAM. This block holds only the pointers, the
//   occupancy count and the sticky error flags.
//
// Parameters:
//   ADDR_WIDTH  RAM address width; FIFO depth is 2**ADDR_WIDTH.
//   DATA_WIDTH  data word width.
//   AF_THRESH   almost_full asserts when count >= AF_THRESH (1..DEPTH).
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   wr_en        push request
//   wr_data      push data
//   full         count == DEPTH
//   almost_full  count >= AF_THRESH
//   rd_en        pop request
//   rd_data      head-of-FIFO data, meaningful while rd_valid = 1
//   rd_valid     FIFO not empty
//   count        occupancy, 0..DEPTH
//   overflow     sticky: push attempted while full
//   underflow    sticky: pop attempted while empty
//   ram_we       RAM write enable
//   ram_waddr    RAM write address
//   ram_wdata    RAM write data
//   ram_raddr    RAM read address (registered inside the RAM)
//   ram_dout     RAM read data
// ---------------------------------------------------------------------------
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 4,
    parameter int AF_THRESH  = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  push;
    logic                  pop;

    // Status outputs are decoded from registered state only.
    always_comb begin
        count       = cnt;
        full        = (cnt == DEPTH_C);
        rd_valid    = (cnt != '0);
        almost_full = (cnt >= AF_C);
        overflow    = overflow_q;
        underflow   = underflow_q;
    end

    // Push and pop are judged independently: a pop in the same cycle does
    // not make room for a push into a full FIFO, and a push into an empty
    // FIFO cannot be popped in the same cycle.
    always_comb begin
        push = wr_en & ~full & ~rst;
        pop  = rd_en & rd_valid & ~rst;
    end

    // The read address always presents the head pointer as it will be
    // after this edge. Because the RAM registers raddr, its dout after the
    // edge is the new head word, so rd_data needs no register and a pop
    // stream has no bubbles. A write into an empty FIFO lands on the same
    // edge that latches raddr == wr_ptr, so the new word falls through.
    always_comb begin
        ram_we    = push;
        ram_waddr = wr_ptr;
        ram_wdata = wr_data;
        rd_data   = ram_dout;
        if (rst) begin
            ram_raddr = '0;
        end else if (pop) begin
            ram_raddr = rd_ptr + ADDR_WIDTH'(1);
        end else begin
            ram_raddr = rd_ptr;
        end
    end

    // Pointers wrap naturally at DEPTH; cnt carries the extra bit that
    // distinguishes full from empty when the pointers are equal.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && !rd_valid) begin
                underflow_q <= 1'b1;
            end
        end
    end

endmodule
